// File: rtl/sfb_pkg.sv
// rtl/sfb_pkg.sv - shared constants, types and config checks for sample_frame_buffer
package sfb_pkg;

  localparam logic [1:0] MAX_FULL = 2'd2;

  typedef logic bank_t;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sfb_sdp_ram.sv
// rtl/sfb_sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
module sfb_sdp_ram #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array or the read register so the tools map it onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sample_frame_buffer.sv
// rtl/sample_frame_buffer.sv - ping-pong audio frame buffer feeding the FFT; SFB_OVERRUN_CNT_EN adds a drop counter
module sample_frame_buffer
  import sfb_pkg::*;
#(
  parameter int DATA_W    = 10,
  parameter int FRAME_LEN = 1024,
  parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] fill_level,
  output logic              frame_avail,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              frame_release,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic [15:0]       overrun_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  if (!is_pow2(FRAME_LEN) || FRAME_LEN < 4 || ADDR_W != $clog2(FRAME_LEN)) begin : g_bad_cfg
    $error("sample_frame_buffer: FRAME_LEN must be a power of 2 >= 4 and ADDR_W must not be overridden");
  end

  bank_t             wr_bank;
  bank_t             rd_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        full_cnt;
  logic              rd_seen;
  logic [DATA_W-1:0] ram_q;

  logic wr_accept;
  logic wr_drop;
  logic wr_wrap;
  logic rd_accept;
  logic rel_accept;

  assign frame_avail = (full_cnt != 2'd0);
  assign fill_level  = wr_addr;

  assign wr_accept  = wr_valid && (full_cnt < MAX_FULL);
  assign wr_drop    = wr_valid && (full_cnt >= MAX_FULL);
  assign wr_wrap    = wr_accept && (wr_addr == LAST_ADDR);
  assign rd_accept  = rd_en && frame_avail;
  assign rel_accept = frame_release && frame_avail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_addr  <= '0;
      full_cnt <= 2'd0;
      rd_valid <= 1'b0;
      rd_seen  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (wr_accept) wr_addr <= wr_addr + ADDR_W'(1);
      if (wr_wrap) wr_bank <= ~wr_bank;
      if (rel_accept) rd_bank <= ~rd_bank;
      // A completing frame and a release in the same cycle cancel out.
      case ({wr_wrap, rel_accept})
        2'b10:   full_cnt <= full_cnt + 2'd1;
        2'b01:   full_cnt <= full_cnt - 2'd1;
        default: full_cnt <= full_cnt;
      endcase
      rd_valid <= rd_accept;
      if (rd_accept) rd_seen <= 1'b1;
      if (wr_drop) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  // The RAM read register has no reset; rd_seen masks it to zero until the first accepted read.
  assign rd_data = rd_seen ? ram_q : '0;

  sfb_sdp_ram #(
    .DATA_W(DATA_W),
    .DEPTH (2 * FRAME_LEN)
  ) u_ram (
    .clk  (clk),
    .we   (wr_accept),
    .waddr({wr_bank, wr_addr}),
    .wdata(wr_data),
    .re   (rd_accept),
    .raddr({rd_bank, rd_addr}),
    .rdata(ram_q)
  );

`ifdef SFB_OVERRUN_CNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 16'h0;
    end else if (wr_drop) begin
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'h1;
    end else if (overrun_clr) begin
      drop_cnt <= 16'h0;
    end
  end

  assign overrun_cnt = drop_cnt;
`else
  assign overrun_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_sample_frame_buffer.sv
// tb/tb_sample_frame_buffer.sv - self-checking bench for sample_frame_buffer with a frame-queue model
module tb_sample_frame_buffer;

  localparam int DATA_W    = 10;
  localparam int FRAME_LEN = 8;
  localparam int ADDR_W    = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [ADDR_W-1:0] fill_level;
  logic              frame_avail;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              frame_release = 1'b0;
  logic              overrun;
  logic              overrun_clr = 1'b0;
  logic [15:0]       overrun_cnt;

  always #5 clk = ~clk;

  sample_frame_buffer #(
    .DATA_W   (DATA_W),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .fill_level   (fill_level),
    .frame_avail  (frame_avail),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .frame_release(frame_release),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .overrun_cnt  (overrun_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef SFB_OVERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // Model: completed frames wait in a FIFO, the frame being filled is built separately.
  logic [FRAME_LEN*DATA_W-1:0] full_q[$];
  logic [FRAME_LEN*DATA_W-1:0] cur;
  logic [FRAME_LEN*DATA_W-1:0] head;
  int                          cur_n;
  logic                        m_rd_valid;
  logic [DATA_W-1:0]           m_rd_data;
  logic                        m_ovr;
  int                          m_cnt;

  task model_reset();
    full_q.delete();
    cur_n      = 0;
    m_rd_valid = 1'b0;
    m_rd_data  = '0;
    m_ovr      = 1'b0;
    m_cnt      = 0;
  endtask

  initial model_reset();
  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    int n_full;
    bit avail;
    if (!rst_n) begin
      model_reset();
    end else begin
      n_full = full_q.size();
      avail  = (n_full != 0);
      m_rd_valid = rd_en && avail;
      if (rd_en && avail) begin
        head = full_q[0];
        m_rd_data = head[int'(rd_addr)*DATA_W +: DATA_W];
      end
      if (frame_release && avail) void'(full_q.pop_front());
      if (wr_valid && n_full < 2) begin
        cur[cur_n*DATA_W +: DATA_W] = wr_data;
        if (cur_n == FRAME_LEN - 1) begin
          full_q.push_back(cur);
          cur_n = 0;
        end else begin
          cur_n++;
        end
      end
      if (wr_valid && n_full >= 2) begin
        m_ovr = 1'b1;
        if (CNT_EN && m_cnt < 65535) m_cnt++;
      end else if (overrun_clr) begin
        m_ovr = 1'b0;
        m_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("fill_level", 32'(fill_level), cur_n);
      check("frame_avail", 32'(frame_avail), 32'(full_q.size() != 0));
      check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      check("rd_data", 32'(rd_data), 32'(m_rd_data));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("overrun_cnt", 32'(overrun_cnt), m_cnt);
    end
  end

  task automatic step(input logic wv, input logic [DATA_W-1:0] wd, input logic re,
                      input logic [ADDR_W-1:0] ra, input logic rel, input logic clr);
    @(negedge clk);
    wr_valid      = wv;
    wr_data       = wd;
    rd_en         = re;
    rd_addr       = ra;
    frame_release = rel;
    overrun_clr   = clr;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wr(input int d);
    step(1'b1, DATA_W'(d), 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wr_run(input int base, input int n);
    for (int i = 0; i < n; i++) wr(base + i);
  endtask

  task automatic rd(input int a);
    step(1'b0, '0, 1'b1, ADDR_W'(a), 1'b0, 1'b0);
    idle();
  endtask

  task automatic rel();
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("lit_reset_fill", 32'(fill_level), 0);
    check("lit_reset_avail", 32'(frame_avail), 0);
    check("lit_reset_rd_valid", 32'(rd_valid), 0);
    check("lit_reset_rd_data", 32'(rd_data), 0);
    check("lit_reset_overrun", 32'(overrun), 0);
    check("lit_reset_cnt", 32'(overrun_cnt), 0);
    rst_n = 1'b1;

    // Single frame
    wr_run(0, 7);
    idle();
    check("lit_single_avail_7", 32'(frame_avail), 0);
    check("lit_single_fill_7", 32'(fill_level), 7);
    wr(7);
    idle();
    check("lit_single_avail_8", 32'(frame_avail), 1);
    check("lit_single_fill_8", 32'(fill_level), 0);
    rd(3);
    check("lit_single_rd_valid", 32'(rd_valid), 1);
    check("lit_single_rd_data", 32'(rd_data), 3);
    idle();
    check("lit_single_rd_valid_drop", 32'(rd_valid), 0);
    rel();
    check("lit_single_release", 32'(frame_avail), 0);

    // Ping-pong
    wr_run(0, 16);
    idle();
    check("lit_pp_avail", 32'(frame_avail), 1);
    rd(0);
    check("lit_pp_rd0", 32'(rd_data), 0);
    rel();
    check("lit_pp_avail_after_rel", 32'(frame_avail), 1);
    rd(0);
    check("lit_pp_rd0_second", 32'(rd_data), 8);

    // Frame completion coinciding with release
    wr_run(100, 7);
    step(1'b1, DATA_W'(107), 1'b0, '0, 1'b1, 1'b0);
    idle();
    check("lit_sim_avail", 32'(frame_avail), 1);
    check("lit_sim_fill", 32'(fill_level), 0);
    rd(0);
    check("lit_sim_rd0", 32'(rd_data), 100);
    rd(7);
    check("lit_sim_rd7", 32'(rd_data), 107);
    // Read and release together: read comes from the old bank
    step(1'b0, '0, 1'b1, 3'd5, 1'b1, 1'b0);
    idle();
    check("lit_rdrel_data", 32'(rd_data), 105);
    check("lit_rdrel_avail", 32'(frame_avail), 0);

    // Invalid requests with no frame available
    rd(2);
    check("lit_inv_rd_valid", 32'(rd_valid), 0);
    check("lit_inv_rd_data", 32'(rd_data), 105);
    rel();
    check("lit_inv_rel_avail", 32'(frame_avail), 0);
    wr_run(300, 8);
    idle();
    check("lit_inv_refill", 32'(frame_avail), 1);
    rel();
    check("lit_inv_rel_after_refill", 32'(frame_avail), 0);

    // Overrun
    wr_run(200, 16);
    wr_run(900, 3);
    idle();
    check("lit_ovr_flag", 32'(overrun), 1);
    check("lit_ovr_cnt", 32'(overrun_cnt), CNT_EN ? 3 : 0);
    check("lit_ovr_fill", 32'(fill_level), 0);
    rd(7);
    check("lit_ovr_rd7", 32'(rd_data), 207);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle();
    check("lit_ovr_clr_flag", 32'(overrun), 0);
    check("lit_ovr_clr_cnt", 32'(overrun_cnt), 0);
    wr(903);
    idle();
    check("lit_ovr_again", 32'(overrun), 1);
    step(1'b1, DATA_W'(904), 1'b0, '0, 1'b0, 1'b1);
    idle();
    check("lit_ovr_set_wins", 32'(overrun), 1);
    check("lit_ovr_set_wins_cnt", 32'(overrun_cnt), CNT_EN ? 2 : 0);
    rel();
    rd(0);
    check("lit_ovr_rd_second", 32'(rd_data), 208);
    rd(2);
    check("lit_ovr_rd_second2", 32'(rd_data), 210);
    rel();
    check("lit_ovr_empty", 32'(frame_avail), 0);

    // Reset mid-frame
    wr_run(400, 5);
    idle();
    check("lit_mid_fill", 32'(fill_level), 5);
    #2 rst_n = 1'b0;
    #1;
    check("lit_rst_fill", 32'(fill_level), 0);
    check("lit_rst_avail", 32'(frame_avail), 0);
    check("lit_rst_overrun", 32'(overrun), 0);
    check("lit_rst_cnt", 32'(overrun_cnt), 0);
    check("lit_rst_rd_valid", 32'(rd_valid), 0);
    check("lit_rst_rd_data", 32'(rd_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_run(0, 8);
    idle();
    check("lit_post_rst_avail", 32'(frame_avail), 1);
    rd(5);
    check("lit_post_rst_rd5", 32'(rd_data), 5);
    rel();
    repeat (2) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
